dram_burst_ctrl: RTL and testbench

//  Request sequencer sitting directly upstream of the 4096x32 single-port data RAM.

---
 rtl/dram_burst_ctrl.sv | 153 +++++++++++++++
 tb/tb_dram_burst_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_ctrl.sv
// dram_burst_ctrl: single/burst request sequencer in front of a 4096x32
// single-port RAM whose read address is registered (q follows addr by one
// cycle). Writes stream one beat per accepted wr_valid; reads take three
// cycles per beat (present address, capture q, hand out beat).
//
// Optional feature: define DRAM_BOUNDS_CHECK_EN to reject requests whose
// burst would run past the top of memory (err pulse, no RAM access).
// Without it, bursts wrap modulo 2**ADDR_W and err is always 0.
//
// Handshakes: every valid/ready pair transfers exactly on a rising edge where
// both are 1. A valid, once raised, is held with stable payload until that
// edge; ready may change freely and never depends on the partner's valid.
module dram_burst_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    RD_OUT  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beats_left;
  logic              req_bad;

`ifdef DRAM_BOUNDS_CHECK_EN
  // One past the last word the burst would touch; must not exceed 2**ADDR_W.
  logic [ADDR_W:0] end_addr;
  assign end_addr = {1'b0, req_addr} + (ADDR_W+1)'(req_len) + (ADDR_W+1)'(1);
  assign req_bad  = (end_addr > {1'b1, {ADDR_W{1'b0}}});
`else
  assign req_bad = 1'b0;
`endif

  // RAM pins follow the current address; write data passes straight through.
  assign ram_addr = cur_addr;
  assign ram_data = wr_data;
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and per-state handshake/RAM strobes.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    rd_last   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_bad) state_nx = req_we ? WR : RD_ADDR;
      end
      WR: begin
        wr_ready = 1'b1;
        ram_we   = wr_valid;
        if (wr_valid && (beats_left == '0)) state_nx = IDLE;
      end
      RD_ADDR: state_nx = RD_CAP;
      RD_CAP:  state_nx = RD_OUT;
      RD_OUT: begin
        rd_last = (beats_left == '0);
        if (rd_ready) state_nx = rd_last ? IDLE : RD_ADDR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address/beat counters, read data capture and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr   <= '0;
      beats_left <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              err <= 1'b1;
            end else begin
              cur_addr   <= req_addr;
              beats_left <= req_len;
            end
          end
        end
        WR: begin
          if (wr_valid) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            if (beats_left == '0) done <= 1'b1;
            else                  beats_left <= beats_left - LEN_W'(1);
          end
        end
        RD_CAP: begin
          // q now reflects the address the RAM latched at the previous edge.
          rd_data  <= ram_q;
          rd_valid <= 1'b1;
        end
        RD_OUT: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (beats_left == '0) begin
              done <= 1'b1;
            end else begin
              cur_addr   <= cur_addr + ADDR_W'(1);
              beats_left <= beats_left - LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_burst_ctrl.sv
// Self-checking bench for dram_burst_ctrl with a behavioural registered-read
// RAM attached to the RAM pins. Read beats and RAM writes are checked by a
// scoreboard against expected queues filled when stimulus is driven.
module tb_dram_burst_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b1;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  dram_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done), .err(err),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Clock.
  always #5 clk = ~clk;

  // Behavioural single-port RAM: synchronous write, registered read address.
  logic [DATA_W-1:0] mem [0:4095];
  logic [ADDR_W-1:0] addr_reg = '0;
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_data;
    addr_reg <= ram_addr;
  end
  assign ram_q = mem[addr_reg];

  // Reference memory contents as the bench believes they were written.
  logic [DATA_W-1:0] ref_mem [0:4095];

  // Scoreboard state.
  logic [DATA_W:0]          exp_q[$];   // {last, data}
  logic [ADDR_W+DATA_W-1:0] wexp_q[$];  // {addr, data}
  logic [DATA_W:0]          rd_e;
  logic [ADDR_W+DATA_W-1:0] wr_e;
  int n_checks = 0;
  int n_fail   = 0;
  int we_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop expectations when a read beat or a RAM write happens.
  always @(negedge clk) begin
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got %0h expected no beat", rd_data);
      end else begin
        rd_e = exp_q.pop_front();
        check("rd_data", 64'(rd_data), 64'(rd_e[DATA_W-1:0]));
        check("rd_last", 64'(rd_last), 64'(rd_e[DATA_W]));
      end
    end
    if (ram_we === 1'b1) begin
      we_count++;
      if (wexp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL ram_we_unexpected: got addr %0h data %0h expected no write", ram_addr, ram_data);
      end else begin
        wr_e = wexp_q.pop_front();
        check("ram_write", 64'({ram_addr, ram_data}), 64'(wr_e));
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  // Driver tasks (all drive at posedge+1).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    int guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    wexp_q.push_back({a, d});
    ref_mem[a] = d;
  endtask

  task automatic write_beats(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                             input logic [DATA_W-1:0] base, input int gap_at);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == gap_at) begin
        wr_valid = 1'b0;
        tick();
      end
      a = addr + ADDR_W'(i);
      drive_beat(a, base + DATA_W'(i));
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int   guard = 0;
    logic seen  = 1'b0;
    while (!seen && guard < 200) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      guard++;
    end
    check(name, 64'(seen), 64'd1);
    tick();
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                          input logic [DATA_W-1:0] base, input int gap_at);
    issue(1'b1, addr, len);
    write_beats(addr, len, base, gap_at);
    wait_done("wr_done");
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + ADDR_W'(i);
      exp_q.push_back({(i == int'(len)), ref_mem[a]});
    end
    issue(1'b0, addr, len);
    wait_done("rd_done");
  endtask

  // Table of vectors: writes give data base and expected we pulse count;
  // reads give the literal expected data base (beat i = exp_base + i).
  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] base;
    int                exp_we;
    logic [DATA_W-1:0] exp_base;
  } vec_t;

  vec_t vecs [8];
  int   n_vec;

  initial begin
    int we0;
    int lat;
    logic seen;
    logic [ADDR_W-1:0] ra;
    logic [LEN_W-1:0]  rl;
    logic [DATA_W-1:0] rb;

    n_vec = 0;
    vecs[n_vec++] = '{1'b1, 12'd5,    4'd0,  32'hDEADBEEF, 1,  32'h0};
    vecs[n_vec++] = '{1'b0, 12'd5,    4'd0,  32'h0,        0,  32'hDEADBEEF};
    vecs[n_vec++] = '{1'b1, 12'd300,  4'd15, 32'h00001000, 16, 32'h0};
    vecs[n_vec++] = '{1'b0, 12'd300,  4'd15, 32'h0,        0,  32'h00001000};
`ifndef DRAM_BOUNDS_CHECK_EN
    vecs[n_vec++] = '{1'b1, 12'd4094, 4'd2,  32'h000000A0, 3,  32'h0};
    vecs[n_vec++] = '{1'b0, 12'd4094, 4'd2,  32'h0,        0,  32'h000000A0};
    vecs[n_vec++] = '{1'b0, 12'd0,    4'd0,  32'h0,        0,  32'h000000A2};
`endif

    // Reset block.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_wr_ready",  64'(wr_ready),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_rd_valid",  64'(rd_valid),  64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_err",       64'(err),       64'd0);
    check("rst_ram_we",    64'(ram_we),    64'd0);
    check("rst_rd_data",   64'(rd_data),   64'd0);
    check("rst_ram_addr",  64'(ram_addr),  64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven vectors.
    for (int v = 0; v < n_vec; v++) begin
      if (vecs[v].we) begin
        we0 = we_count;
        do_write(vecs[v].addr, vecs[v].len, vecs[v].base, -1);
        check("vec_we_pulses", 64'(we_count - we0), 64'(vecs[v].exp_we));
      end else begin
        for (int i = 0; i <= int'(vecs[v].len); i++)
          exp_q.push_back({(i == int'(vecs[v].len)), vecs[v].exp_base + DATA_W'(i)});
        issue(1'b0, vecs[v].addr, vecs[v].len);
        wait_done("vec_rd_done");
      end
    end

    // Single read latency: rd_valid 3 cycles after the accept cycle.
    rd_ready = 1'b1;
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    issue(1'b0, 12'd5, 4'd0);
    lat = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) lat = n;
    end
    check("rd_latency", 64'(lat), 64'd3);
    check("rd_last_single", 64'(rd_last), 64'd1);
    @(negedge clk);
    check("done_after_read", 64'(done), 64'd1);
    tick();

    // Write burst with a wr_valid gap after beat 2, then read back.
    we0 = we_count;
    do_write(12'd16, 4'd3, 32'd1, 2);
    check("gap_we_pulses", 64'(we_count - we0), 64'd4);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 32'(i + 1)});
    issue(1'b0, 12'd16, 4'd3);
    wait_done("gap_rd_done");

    // Read len=1 with rd_ready held low for 5 cycles on beat 0.
    do_write(12'd100, 4'd1, 32'h12340000, -1);
    rd_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h12340000});
    exp_q.push_back({1'b1, 32'h12340001});
    issue(1'b0, 12'd100, 4'd1);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) seen = 1'b1;
    end
    check("stall_rd_valid_seen", 64'(seen), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("stall_rd_data",  64'(rd_data),  64'h12340000);
      check("stall_ram_addr", 64'(ram_addr), 64'd100);
      check("stall_rd_last",  64'(rd_last),  64'd0);
      check("stall_rd_valid", 64'(rd_valid), 64'd1);
      if (k < 4) @(negedge clk);
    end
    tick();
    rd_ready = 1'b1;
    wait_done("stall_rd_done");

    // Random write/read pairs that stay below the top of memory.
    for (int r = 0; r < 4; r++) begin
      ra = ADDR_W'($urandom_range(0, 4095 - 16));
      rl = LEN_W'($urandom_range(0, 15));
      rb = $urandom;
      do_write(ra, rl, rb, (r == 1) ? 1 : -1);
      do_read(ra, rl);
    end

    // Reset during beat 2 of a len=7 write.
    we0 = we_count;
    issue(1'b1, 12'd200, 4'd7);
    drive_beat(12'd200, 32'hC0);
    tick();
    drive_beat(12'd201, 32'hC1);
    tick();
    drive_beat(12'd202, 32'hC2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 32'hBAD0;
    @(negedge clk);
    check("rstmid_ram_we",    64'(ram_we),    64'd0);
    check("rstmid_busy",      64'(busy),      64'd0);
    check("rstmid_req_ready", 64'(req_ready), 64'd1);
    check("rstmid_done",      64'(done),      64'd0);
    tick();
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstmid_no_done", 64'(done), 64'd0);
    end
    check("rstmid_we_pulses", 64'(we_count - we0), 64'd3);
    tick();

`ifdef DRAM_BOUNDS_CHECK_EN
    // Out-of-range request is consumed with an err pulse and no access.
    we0 = we_count;
    issue(1'b0, 12'd4090, 4'd7);
    @(negedge clk);
    check("bounds_err",  64'(err),  64'd1);
    check("bounds_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bounds_err_pulse", 64'(err),      64'd0);
      check("bounds_rd_valid",  64'(rd_valid), 64'd0);
      check("bounds_done",      64'(done),     64'd0);
    end
    check("bounds_no_we", 64'(we_count - we0), 64'd0);
    tick();
    do_write(12'd4088, 4'd7, 32'h00F00000, -1);
    do_read(12'd4088, 4'd7);
`endif

    // Final report.
    check("exp_q_drained",  64'(exp_q.size()),  64'd0);
    check("wexp_q_drained", 64'(wexp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
